// File: rtl/pipe_buf_stage.sv
// pipe_buf_stage: two-entry pipeline buffer (MAIN head + SKID) with a registered in_ready,
// so the upstream ready never depends combinationally on out_ready.
//
// Parameters:
//   WIDTH  payload width in bits (1..512)
//   CNT_W  width of each performance counter
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-low reset
//   in_valid   upstream offers in_data
//   in_ready   stage can accept this cycle (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a live payload
//   out_ready  downstream consumes this cycle
//   out_data   head payload (MAIN)
//   flush      discard all held payloads
//   level      occupancy 0..2
//   stall_cnt  cycles with out_valid=1 and out_ready=0 (saturating)
//   flush_cnt  cycles with flush=1 (saturating)
//
// Build option: define PIPE_BUF_PERF_EN to enable the performance counters; otherwise
// stall_cnt and flush_cnt are tied to zero and no counter flops exist.

module pipe_buf_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A payload accepted alongside a flush is dropped; a pop still completes.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = StTwo;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    // Ready for next cycle is decided from the next state, keeping it a pure flop output.
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Outputs.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q != StEmpty);
    out_data  = main_q;
    level     = 2'd0;
    unique case (state_q)
      StEmpty: level = 2'd0;
      StOne:   level = 2'd1;
      StTwo:   level = 2'd2;
      default: level = 2'd0;
    endcase
  end

`ifdef PIPE_BUF_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Both counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
